// File: rtl/my_multicycle_leftshifter_pkg.sv
// Shared types and constants for the iterative left shifter.
package my_multicycle_leftshifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int STAGE_SHIFT     = 4;
  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_SHAMT_W = 5;

endpackage

// File: rtl/my_4bit_leftshifter.sv
// One combinational left-shift stage: moves data up by STAGE_SHIFT bits when enabled.
module my_4bit_leftshifter
  import my_multicycle_leftshifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data_input,
  input  logic             control_bit,
  output logic [WIDTH-1:0] data_output
);

  assign data_output = control_bit
                     ? {data_input[WIDTH-1-STAGE_SHIFT:0], {STAGE_SHIFT{1'b0}}}
                     : data_input;

endmodule

// File: rtl/my_multicycle_leftshifter.sv
// Iterative logical left shifter: four bit positions per cycle, then a 0..3 residual step.
module my_multicycle_leftshifter
  import my_multicycle_leftshifter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy
);

  localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(STAGE_SHIFT);

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] rem;
  logic [WIDTH-1:0]   stage_out;
  logic [WIDTH-1:0]   residual_out;
  logic               stage_en;

  assign stage_en = (rem >= STEP);
  assign data_out = acc;

  my_4bit_leftshifter #(.WIDTH(WIDTH)) u_stage (
    .data_input  (acc),
    .control_bit (stage_en),
    .data_output (stage_out)
  );

  // Final partial step once fewer than four positions remain.
  always_comb begin
    residual_out = acc;
    case (rem[1:0])
      2'd0:    residual_out = acc;
      2'd1:    residual_out = {acc[WIDTH-2:0], 1'b0};
      2'd2:    residual_out = {acc[WIDTH-3:0], 2'b00};
      default: residual_out = {acc[WIDTH-4:0], 3'b000};
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      rem       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            acc      <= data_in;
            rem      <= shamt;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          if (stage_en) begin
            acc <= stage_out;
            rem <= rem - STEP;
          end else begin
            acc       <= residual_out;
            rem       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
